iter_alu: RTL

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/alu_pkg.sv | 30 +++
 rtl/iter_muldiv.sv | 96 +++++++++
 rtl/iter_alu.sv | 91 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode values and iteration-FSM state encoding for the iterative ALU.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD = 5'b00001,
    OP_SUB = 5'b00010,
    OP_AND = 5'b00011,
    OP_OR  = 5'b00100,
    OP_SHR = 5'b00101,
    OP_SHL = 5'b00110,
    OP_ROR = 5'b00111,
    OP_ROL = 5'b01000,
    OP_MUL = 5'b01001,
    OP_DIV = 5'b01010,
    OP_NEG = 5'b01011,
    OP_NOT = 5'b01100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } iter_state_e;

  // A divide by zero is resolved in one cycle, so only a real divide iterates.
  function automatic logic is_iter_op(logic [4:0] op, logic b_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one iteration per cycle, down-counter reaches 0 on the last one
//   FIN   | result valid, done high for one cycle; a new start is accepted here
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  iter_state_e        state_q, state_d;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_nxt;
  logic [WIDTH-1:0]   opd_q;
  logic               div_q;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = start ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One iteration step. acc holds {hi, lo}: product/multiplier for MUL,
  // remainder/dividend-becoming-quotient for DIV.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
    div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = (div_rem >= {1'b0, opd_q});
    div_diff = div_rem[WIDTH-1:0] - opd_q;
    if (div_q) begin
      acc_nxt = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                       : {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // State, iteration counter, operand latch and result register.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      div_q   <= 1'b0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      if (start && (state_q != ST_RUN)) begin
        cnt_q <= SHW'(WIDTH - 1);
        div_q <= is_div;
        opd_q <= is_div ? b : a;
        acc_q <= {{WIDTH{1'b0}}, (is_div ? a : b)};
      end else if (state_q == ST_RUN) begin
        acc_q <= acc_nxt;
        if (cnt_q != '0) cnt_q <= cnt_q - SHW'(1);
        else             result <= acc_nxt;
      end
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU top: single-cycle ops computed here, MUL/DIV handed to iter_muldiv.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] C,
  output logic               busy,
  output logic               done,
  output logic               dbz
);

  logic               accept, long_op, md_start, md_busy, md_done;
  logic [2*WIDTH-1:0] md_result;
  logic [2*WIDTH-1:0] alu_res, c_q;
  logic               alu_dbz, dbz_q, done_q, md_sel;
  logic [SHW-1:0]     sh;

  assign sh       = B[SHW-1:0];
  assign accept   = start && !md_busy;
  assign long_op  = is_iter_op(opcode, (B == '0));
  assign md_start = accept && long_op;

  iter_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk    (clk),
    .clr    (clr),
    .start  (md_start),
    .is_div (opcode == OP_DIV),
    .a      (A),
    .b      (B),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // Single-cycle result; upper half is zero except the ADD/SUB carry bit and DIV-by-zero.
  always_comb begin
    alu_res = '0;
    alu_dbz = 1'b0;
    case (opcode)
      OP_ADD: alu_res = {{(WIDTH-1){1'b0}}, ({1'b0, A} + {1'b0, B})};
      OP_SUB: alu_res = {{(WIDTH-1){1'b0}}, ({1'b0, A} - {1'b0, B})};
      OP_AND: alu_res = {{WIDTH{1'b0}}, (A & B)};
      OP_OR:  alu_res = {{WIDTH{1'b0}}, (A | B)};
      OP_SHR: alu_res = {{WIDTH{1'b0}}, (A >> sh)};
      OP_SHL: alu_res = {{WIDTH{1'b0}}, (A << sh)};
      OP_ROR: alu_res = {{WIDTH{1'b0}}, ((A >> sh) | (A << (WIDTH - int'(sh))))};
      OP_ROL: alu_res = {{WIDTH{1'b0}}, ((A << sh) | (A >> (WIDTH - int'(sh))))};
      OP_NEG: alu_res = {{WIDTH{1'b0}}, (-A)};
      OP_NOT: alu_res = {{WIDTH{1'b0}}, (~A)};
      OP_DIV: begin
        alu_res = {A, {WIDTH{1'b1}}};
        alu_dbz = 1'b1;
      end
      default: alu_res = '0;
    endcase
  end

  // Result register for single-cycle ops; md_sel remembers that the last
  // completed op came from the iterative unit, whose result register holds it.
  always_ff @(posedge clk) begin
    if (!clr) begin
      c_q    <= '0;
      dbz_q  <= 1'b0;
      done_q <= 1'b0;
      md_sel <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (md_done) md_sel <= 1'b1;
      if (accept && !long_op) begin
        c_q    <= alu_res;
        dbz_q  <= alu_dbz;
        done_q <= 1'b1;
        md_sel <= 1'b0;
      end
    end
  end

  assign C    = (md_sel || md_done) ? md_result : c_q;
  assign dbz  = (md_sel || md_done) ? 1'b0 : dbz_q;
  assign done = done_q || md_done;
  assign busy = md_busy;

endmodule
